// File: rtl/wb_stage.sv
// Write-back stage: captures retiring instructions, waits for load data, formats it,
// and drives the register-file write port plus pending-load and retire-count status.
module wb_stage #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_regwrite,
    input  logic [4:0]          in_rd,
    input  logic [1:0]          in_wb_sel,
    input  logic [31:0]         in_alu,
    input  logic [31:0]         in_pc4,
    input  logic [31:0]         in_imm,
    input  logic [2:0]          in_ld_type,
    input  logic [1:0]          in_addr_lo,
    input  logic                dmem_rvalid,
    input  logic [31:0]         dmem_rdata,
    output logic                RFWr,
    output logic [31:0]         wR,
    output logic [31:0]         wD,
    output logic                load_busy,
    output logic [4:0]          load_rd,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [1:0] {EMPTY, WAIT_LOAD, COMMIT} state_t;

    state_t      state;
    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [2:0]  ld_type_q;
    logic [1:0]  addr_lo_q;
    logic        accept;
    logic [31:0] sel_data;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign in_ready = (state == EMPTY) || (state == COMMIT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_type_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (in_wb_sel)
            2'd2:    sel_data = in_pc4;
            2'd3:    sel_data = in_imm;
            default: sel_data = in_alu;
        endcase
    end

    // Outputs are registered alongside the state, so RFWr/wR/wD are set on entry to COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            ld_type_q  <= '0;
            addr_lo_q  <= '0;
            RFWr       <= 1'b0;
            wR         <= '0;
            wD         <= '0;
            load_busy  <= 1'b0;
            load_rd    <= '0;
            retired    <= '0;
        end else begin
            RFWr      <= 1'b0;
            load_busy <= 1'b0;
            load_rd   <= '0;
            if (state == COMMIT)
                retired <= retired + RETIRE_W'(1);
            case (state)
                EMPTY, COMMIT: begin
                    if (accept) begin
                        regwrite_q <= in_regwrite;
                        rd_q       <= in_rd;
                        ld_type_q  <= in_ld_type;
                        addr_lo_q  <= in_addr_lo;
                        if (in_wb_sel == 2'd1) begin
                            state     <= WAIT_LOAD;
                            load_busy <= 1'b1;
                            load_rd   <= in_rd;
                        end else begin
                            state <= COMMIT;
                            RFWr  <= in_regwrite && (in_rd != 5'd0);
                            wR    <= {27'b0, in_rd};
                            wD    <= sel_data;
                        end
                    end else begin
                        state <= EMPTY;
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        state <= COMMIT;
                        RFWr  <= regwrite_q && (rd_q != 5'd0);
                        wR    <= {27'b0, rd_q};
                        wD    <= ld_data;
                    end else begin
                        load_busy <= 1'b1;
                        load_rd   <= rd_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed plan steps followed by randomized
// instructions, checked against a spec-level model of commit, formatting and counting.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [31:0] in_imm;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        RFWr;
    logic [31:0] wR;
    logic [31:0] wD;
    logic        load_busy;
    logic [4:0]  load_rd;
    logic [31:0] retired;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned exp_ret = 0;
    bit          m_commit = 1'b0;
    logic [31:0] exp_wr = '0;
    logic [31:0] exp_wd = '0;

    wb_stage #(.RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu(in_alu), .in_pc4(in_pc4), .in_imm(in_imm),
        .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .RFWr(RFWr), .wR(wR), .wD(wD), .load_busy(load_busy),
        .load_rd(load_rd), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of the load formatter from the size/sign rules, using shifts and arithmetic.
    function automatic logic [31:0] fmt_ref(input logic [31:0] w, input logic [2:0] t,
                                            input logic [1:0] a);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(a))) & 255;
        h = (w >> (16 * int'(a[1]))) & 65535;
        case (t)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Advance one clock; the retire model counts each cycle the model spent in commit.
    task automatic tick(input bit next_commit);
        @(posedge clk);
        if (rst) exp_ret = 0;
        else if (m_commit) exp_ret++;
        m_commit = next_commit;
        #1;
    endtask

    task automatic idle(input logic rv);
        dmem_rvalid = rv;
        dmem_rdata  = $urandom;
        tick(1'b0);
        dmem_rvalid = 1'b0;
        chk("idle_rfwr", 32'(RFWr), 0);
        chk("idle_wr_hold", wR, exp_wr);
        chk("idle_wd_hold", wD, exp_wd);
        chk("idle_busy", 32'(load_busy), 0);
        chk("idle_ready", 32'(in_ready), 1);
        chk("idle_retired", retired, exp_ret);
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [31:0] rdata, input logic [2:0] ldt, input logic [1:0] alo,
                         input int unsigned dly);
        logic [31:0] d;
        chk("ready_at_issue", 32'(in_ready), 1);
        in_valid = 1'b1; in_regwrite = rw; in_rd = rd; in_wb_sel = sel;
        in_alu = alu; in_pc4 = pc4; in_imm = imm; in_ld_type = ldt; in_addr_lo = alo;
        case (sel)
            2'd0:    d = alu;
            2'd1:    d = fmt_ref(rdata, ldt, alo);
            2'd2:    d = pc4;
            default: d = imm;
        endcase
        if (sel != 2'd1) begin
            tick(1'b1);
            in_valid = 1'b0;
        end else begin
            tick(1'b0);
            for (int unsigned i = 0; i < dly; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_rd    = 5'($urandom);
                chk("wait_busy", 32'(load_busy), 1);
                chk("wait_load_rd", 32'(load_rd), 32'(rd));
                chk("wait_ready", 32'(in_ready), 0);
                chk("wait_rfwr", 32'(RFWr), 0);
                dmem_rdata  = (i == dly - 1) ? rdata : $urandom;
                dmem_rvalid = (i == dly - 1);
                tick(i == dly - 1);
            end
            dmem_rvalid = 1'b0;
            in_valid    = 1'b0;
        end
        exp_wr = 32'(rd);
        exp_wd = d;
        chk("commit_rfwr", 32'(RFWr), 32'(rw && (rd != 5'd0)));
        chk("commit_wr", wR, exp_wr);
        chk("commit_wd", wD, exp_wd);
        chk("commit_busy", 32'(load_busy), 0);
        chk("commit_load_rd", 32'(load_rd), 0);
        chk("commit_retired", retired, exp_ret);
    endtask

    initial begin
        int unsigned r0;
        rst = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_wb_sel = '0;
        in_alu = '0; in_pc4 = '0; in_imm = '0; in_ld_type = '0; in_addr_lo = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;

        tick(1'b0);
        tick(1'b0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_rfwr", 32'(RFWr), 0);
        chk("rst_wr", wR, 0);
        chk("rst_wd", wD, 0);
        chk("rst_busy", 32'(load_busy), 0);
        chk("rst_load_rd", 32'(load_rd), 0);
        chk("rst_retired", retired, 0);
        rst = 1'b0;

        issue(1'b1, 5'd5, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        chk("alu_wd_const", wD, 32'h0000_1234);
        idle(1'b0);
        chk("alu_retired_one", retired, 1);

        issue(1'b1, 5'd1, 2'd0, 32'hA1, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        issue(1'b1, 5'd2, 2'd2, 32'h0, 32'h104, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        issue(1'b1, 5'd3, 2'd3, 32'h0, 32'h0, 32'hABCDE000, 32'h0, 3'd0, 2'd0, 0);
        idle(1'b0);

        issue(1'b1, 5'd10, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01, 3'b000, 2'd3, 1);
        chk("lb_const", wD, 32'hFFFF_FF80);
        issue(1'b1, 5'd11, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01, 3'b100, 2'd3, 2);
        chk("lbu_const", wD, 32'h0000_0080);
        issue(1'b1, 5'd12, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01, 3'b101, 2'd2, 1);
        chk("lhu_const", wD, 32'h0000_80FF);
        issue(1'b1, 5'd13, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01, 3'b001, 2'd0, 1);
        chk("lh_const", wD, 32'h0000_7F01);
        idle(1'b0);

        issue(1'b1, 5'd7, 2'd1, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 3'b010, 2'd1, 4);
        idle(1'b1);
        idle(1'b0);

        r0 = retired;
        issue(1'b1, 5'd0, 2'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        issue(1'b0, 5'd9, 2'd0, 32'hBEEF, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        idle(1'b0);
        chk("x0_nowrite_retired_plus2", retired, r0 + 2);

        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd12; in_wb_sel = 2'd1;
        in_ld_type = 3'b010;
        tick(1'b0);
        in_valid = 1'b0;
        tick(1'b0);
        chk("rstwait_busy", 32'(load_busy), 1);
        chk("rstwait_load_rd", 32'(load_rd), 12);
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        exp_wr = '0;
        exp_wd = '0;
        tick(1'b0);
        dmem_rvalid = 1'b0;
        chk("rstwait_rfwr", 32'(RFWr), 0);
        chk("rstwait_ready", 32'(in_ready), 1);
        chk("rstwait_busy_clr", 32'(load_busy), 0);
        chk("rstwait_retired", retired, exp_ret);
        chk("rstwait_retired_zero", retired, 0);
        chk("rstwait_wr", wR, exp_wr);
        chk("rstwait_wd", wD, exp_wd);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
